// File: rtl/instmem_arb_if.sv
// Fetch/loader bus of the multi-channel instruction memory.
// Channel k's fetch address sits at addr[k*ADDR_WIDTH +: ADDR_WIDTH].
interface instmem_arb_if #(
  parameter int INST_LENGTH = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int NUM_CH      = 4
);
  logic                         load_en;
  logic [ADDR_WIDTH-1:0]        load_addr;
  logic [INST_LENGTH-1:0]       load_data;
  logic                         load_err;
  logic [NUM_CH-1:0]            req;
  logic [NUM_CH*ADDR_WIDTH-1:0] addr;
  logic [NUM_CH-1:0]            gnt;
  logic [NUM_CH-1:0]            rvalid;
  logic [INST_LENGTH-1:0]       rdata;
  logic                         rerr;

  modport master (
    output load_en, load_addr, load_data, req, addr,
    input  load_err, gnt, rvalid, rdata, rerr
  );

  modport slave (
    input  load_en, load_addr, load_data, req, addr,
    output load_err, gnt, rvalid, rdata, rerr
  );
endinterface

// File: rtl/instmem_arb.sv
// Purpose: single-ported program store shared by NUM_CH fetch channels via round-robin arbitration.
// Latency: grant is combinational; rdata/rvalid/rerr registered one cycle after the grant edge.
// Backpressure: a loader write blocks all grants that cycle; unserved requesters hold req/addr.
module instmem_arb #(
  parameter int INST_LENGTH = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int DEPTH       = 256,
  parameter int NUM_CH      = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  instmem_arb_if.slave  bus
);

  localparam int RR_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [RR_W-1:0]     LAST_CH   = RR_W'(NUM_CH - 1);

  logic [INST_LENGTH-1:0] mem [DEPTH];

  logic [RR_W-1:0]        rr;
  logic [RR_W-1:0]        rr_nxt;
  logic [RR_W-1:0]        cand;
  logic [RR_W-1:0]        sel;
  logic                   found;
  logic                   fire;
  logic [NUM_CH-1:0]      gnt_onehot;
  logic [ADDR_WIDTH-1:0]  rd_addr;
  logic                   rd_ok;
  logic                   ld_ok;

  logic [NUM_CH-1:0]      rvalid_q;
  logic [INST_LENGTH-1:0] rdata_q;
  logic                   rerr_q;
  logic                   load_err_q;

  // rr + offset folded back into 0..NUM_CH-1; offset never exceeds NUM_CH-1.
  function automatic logic [RR_W-1:0] wrap_idx(input int v);
    int w;
    w = (v >= NUM_CH) ? v - NUM_CH : v;
    return RR_W'(w);
  endfunction

  always_comb begin
    cand  = '0;
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = wrap_idx(int'(rr) + i);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  assign fire       = found & ~bus.load_en;
  assign gnt_onehot = NUM_CH'(1) << sel;
  assign bus.gnt    = fire ? gnt_onehot : '0;
  assign rr_nxt     = (sel == LAST_CH) ? '0 : sel + RR_W'(1);

  assign rd_addr = bus.addr[sel*ADDR_WIDTH +: ADDR_WIDTH];
  assign rd_ok   = {1'b0, rd_addr} < DEPTH_LIM;
  assign ld_ok   = {1'b0, bus.load_addr} < DEPTH_LIM;

  // Array has no reset so it maps onto plain RAM; out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (bus.load_en && ld_ok) begin
      mem[bus.load_addr[MEM_AW-1:0]] <= bus.load_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr         <= '0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
      rerr_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      rvalid_q   <= bus.gnt;
      rerr_q     <= fire & ~rd_ok;
      load_err_q <= bus.load_en & ~ld_ok;
      if (fire) begin
        rr      <= rr_nxt;
        rdata_q <= rd_ok ? mem[rd_addr[MEM_AW-1:0]] : '0;
      end
    end
  end

  assign bus.rvalid   = rvalid_q;
  assign bus.rdata    = rdata_q;
  assign bus.rerr     = rerr_q;
  assign bus.load_err = load_err_q;

endmodule

// File: doc/instmem_arb.md
# instmem_arb

Multi-channel instruction memory for the tinyGPU: a parametrised successor to the single-port `instmem`. It holds one program image in a single-ported array and serves `NUM_CH` independent fetch channels, one per core/warp, through round-robin arbitration with a request/grant handshake and registered read data. A loader write port programs the array at run time and takes priority over all fetches.

## Interface
- `INST_LENGTH`, 32, instruction width in bits
- `ADDR_WIDTH`, 8, address width
- `DEPTH`, 256, number of words; must satisfy `DEPTH <= 2**ADDR_WIDTH`
- `NUM_CH`, 4, number of fetch channels, range 1..16
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `load_en`  in  1  write strobe from loader
- `load_addr`  in  ADDR_WIDTH  write address
- `load_data`  in  INST_LENGTH  write data
- `req`  in  NUM_CH  per-channel fetch request
- `addr`  in  NUM_CH*ADDR_WIDTH  per-channel fetch address; channel k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH]
- `gnt`  out  NUM_CH  one-hot grant, combinational, same cycle as the accepted request
- `rvalid`  out  NUM_CH  one-hot, data valid for the channel granted in the previous cycle
- `rdata`  out  INST_LENGTH  read data shared by all channels; qualify with `rvalid`
- `rerr`  out  1  high together with `rvalid` when the granted address was >= DEPTH
- `load_err`  out  1  registered; pulses for one cycle after a load to an address >= DEPTH

## Operation
- Storage: DEPTH x INST_LENGTH array, one access per cycle. Contents are not cleared by reset.
- Load priority: when `load_en=1`, the write happens on that edge and `gnt` is all zero. Requests wait.
- Out-of-range load: the write is dropped and `load_err` pulses on the next cycle.
- Arbitration: a round-robin pointer `rr` (range 0..NUM_CH-1) names the highest-priority channel.
  - Search order is `rr, rr+1, …` modulo NUM_CH.
  - The first channel with `req=1` is granted.
  - After a grant to channel k, `rr` becomes (k+1) mod NUM_CH.
  - `rr` holds when there is no grant.
- Handshake:
  - A channel holds `req` and its `addr` stable until it sees `gnt`.
  - A request completes in the cycle where `req & gnt` is true.
  - The channel may keep `req` high to issue back-to-back fetches; it is re-granted when arbitration selects it again.
  - `req` must not be dropped before grant. If it is dropped, no transaction is owed.
- Read: the granted address is registered. On the next edge:
  - `rdata` = mem[addr], or 0 if addr >= DEPTH, in which case `rerr=1`.
  - `rvalid[k]=1` for exactly one cycle.
- Read during load: not possible in the same cycle, because load blocks grants. A read granted the cycle after a load to the same address returns the new data.
- `rdata` holds its last value when `rvalid` is zero.
- With NUM_CH=1, `gnt = req & ~load_en` and `rr` is constant 0.

## Timing
- Reset values (asynchronous, `rst_n=0`): `rvalid=0`, `rdata=0`, `rerr=0`, `load_err=0`, `rr=0`. `gnt` is combinational, so with `rr=0` channel 0 has first priority after reset.
- Read latency: 1 cycle from grant edge to `rvalid`/`rdata`.
- Throughput: one fetch per cycle aggregate. With all N channels requesting continuously, each channel gets one grant every N cycles.
- Reset asserted mid-transaction: a pending `rvalid` is cancelled immediately and no data is returned. After release, requesters re-present `req`.
- Starvation bound: a held request is granted within NUM_CH cycles once `load_en` is low.

## Test plan
- Load then read: write 0xDEAD0000+i to addr i for i=0..15, then fetch each address on channel 0 → each `rvalid[0]` cycle shows `rdata`=0xDEAD0000+i, 1 cycle after `gnt[0]`.
- Round-robin: all 4 channels hold `req` with addr=k → grants cycle 0,1,2,3,0,1…. Each `rvalid[k]` returns mem[k] one cycle after `gnt[k]`.
- Rotation: `rr` at 2, requests on channels 0 and 3 → `gnt`=0b1000 first, then `gnt`=0b0001.
- Load priority: `load_en=1` for 3 cycles while channel 1 requests → `gnt`=0 for those 3 cycles, then `gnt[1]`. A load to addr 5 followed by a fetch of addr 5 returns the new word.
- Out of range (DEPTH=200):
  - Fetch of addr 250 → `rvalid` with `rdata`=0 and `rerr`=1.
  - Load to addr 210 → `load_err` pulses 1 cycle and the array is unchanged.
- Reset mid-fetch: grant on channel 2, then assert `rst_n=0` before the next edge → `rvalid` stays 0 and `rdata`=0. After release, channel 0 wins when channels 0 and 2 both request.
